// File: rtl/push2pull_pkg.sv
// rtl/push2pull_pkg.sv - width helpers and reset constants shared by the push2pull_fifo slice
package push2pull_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned RESET_LEVEL = 0;

endpackage

// File: rtl/push2pull_fifo_mem.sv
// rtl/push2pull_fifo_mem.sv - DEPTH x DWIDTH storage, synchronous write, asynchronous read
module push2pull_fifo_mem
  import push2pull_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ptr_width(DEPTH)-1:0]   wr_addr,
  input  logic [DWIDTH-1:0]             wr_data,
  input  logic [ptr_width(DEPTH)-1:0]   rd_addr,
  output logic [DWIDTH-1:0]             rd_data
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately never reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/push2pull_fifo.sv
// rtl/push2pull_fifo.sv - push-to-pull show-ahead FIFO adapter; PUSH2PULL_FIFO_ERR_EN adds sticky ovf/udf
module push2pull_fifo
  import push2pull_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            push_rdy,
  input  logic                            push_push,
  input  logic [DWIDTH-1:0]               push_dat,
  output logic                            pull_rdy,
  input  logic                            pull_pop,
  output logic [DWIDTH-1:0]               pull_dat,
`ifdef PUSH2PULL_FIFO_ERR_EN
  output logic                            ovf,
  output logic                            udf,
`endif
  output logic [count_width(DEPTH)-1:0]   level
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FULL  = cnt_t'(DEPTH);
  localparam cnt_t EMPTY = cnt_t'(RESET_LEVEL);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic push_acc, pop_acc;

  assign push_rdy = (count_q != FULL);
  assign pull_rdy = (count_q != EMPTY);
  assign level    = count_q;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    push_acc = push_push & push_rdy;
    pop_acc  = pull_pop & pull_rdy;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (push_acc && !pop_acc) begin
      count_d = count_q + cnt_t'(1);
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  push2pull_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_acc & ~rst),
    .wr_addr (wr_ptr_q),
    .wr_data (push_dat),
    .rd_addr (rd_ptr_q),
    .rd_data (pull_dat)
  );

`ifdef PUSH2PULL_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (push_push & ~push_rdy);
    udf_d = udf_q | (pull_pop & ~pull_rdy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_push2pull_fifo.sv
// tb/tb_push2pull_fifo.sv - table-driven and scoreboard bench for push2pull_fifo
module tb_push2pull_fifo;

  localparam int DWIDTH = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              push_rdy;
  logic              push_push;
  logic [DWIDTH-1:0] push_dat;
  logic              pull_rdy;
  logic              pull_pop;
  logic [DWIDTH-1:0] pull_dat;
  logic [2:0]        level;
`ifdef PUSH2PULL_FIFO_ERR_EN
  logic              ovf;
  logic              udf;
`endif

  push2pull_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push_rdy  (push_rdy),
    .push_push (push_push),
    .push_dat  (push_dat),
    .pull_rdy  (pull_rdy),
    .pull_pop  (pull_pop),
    .pull_dat  (pull_dat),
`ifdef PUSH2PULL_FIFO_ERR_EN
    .ovf       (ovf),
    .udf       (udf),
`endif
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [31:0] dat;
    logic        pop;
    logic [2:0]  lvl;
    logic        prdy;
    logic        qrdy;
  } vec_t;

  vec_t        tbl [17];
  logic [31:0] sb [$];
  int          mdl_cnt;
  logic        mdl_ovf;
  logic        mdl_udf;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_flags();
`ifdef PUSH2PULL_FIFO_ERR_EN
    chk("ovf", 32'(ovf), 32'(mdl_ovf));
    chk("udf", 32'(udf), 32'(mdl_udf));
`endif
  endtask

  // One clock of stimulus; accepted pops are checked against the scoreboard head before the edge.
  task automatic cycle(input logic p, input logic [31:0] d, input logic q);
    logic acc_push;
    logic acc_pop;
    logic [31:0] exp_dat;
    acc_push  = p && (mdl_cnt != DEPTH);
    acc_pop   = q && (mdl_cnt != 0);
    push_push = p;
    push_dat  = d;
    pull_pop  = q;
    if (acc_pop) begin
      exp_dat = sb.pop_front();
      chk("pull_dat", pull_dat, exp_dat);
    end
    if (acc_push) sb.push_back(d);
    if (acc_push && !acc_pop) mdl_cnt++;
    if (acc_pop && !acc_push) mdl_cnt--;
    if (p && !acc_push) mdl_ovf = 1'b1;
    if (q && !acc_pop) mdl_udf = 1'b1;
    @(posedge clk);
    #1;
    push_push = 1'b0;
    pull_pop  = 1'b0;
    chk_flags();
  endtask

  task automatic do_reset(input logic p, input logic q);
    rst       = 1'b1;
    push_push = p;
    pull_pop  = q;
    push_dat  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    push_push = 1'b0;
    pull_pop  = 1'b0;
    sb.delete();
    mdl_cnt = 0;
    mdl_ovf = 1'b0;
    mdl_udf = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mdl_cnt = 0;
    mdl_ovf = 1'b0;
    mdl_udf = 1'b0;
    rst = 1'b1;
    push_push = 1'b0;
    pull_pop = 1'b0;
    push_dat = '0;

    tbl[0]  = '{1'b1, 32'h11, 1'b0, 3'd1, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 32'h22, 1'b0, 3'd2, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 32'h33, 1'b0, 3'd3, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 32'h44, 1'b0, 3'd4, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 32'h55, 1'b0, 3'd4, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 32'h00, 1'b1, 3'd3, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 32'h00, 1'b1, 3'd2, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 32'h00, 1'b1, 3'd1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 32'h00, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 32'hBB, 1'b1, 3'd1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 32'h01, 1'b0, 3'd2, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 32'h02, 1'b0, 3'd3, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 32'h03, 1'b0, 3'd4, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 32'hAA, 1'b1, 3'd3, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 32'h00, 1'b1, 3'd2, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 32'h00, 1'b1, 3'd1, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 32'h00, 1'b1, 3'd0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_push_rdy", 32'(push_rdy), 32'd1);
    chk("reset_pull_rdy", 32'(pull_rdy), 32'd0);
    chk_flags();

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].push, tbl[i].dat, tbl[i].pop);
      chk($sformatf("level[%0d]", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("push_rdy[%0d]", i), 32'(push_rdy), 32'(tbl[i].prdy));
      chk($sformatf("pull_rdy[%0d]", i), 32'(pull_rdy), 32'(tbl[i].qrdy));
    end
    chk("table_sb_empty", 32'(sb.size()), 32'd0);

    for (int n = 0; n <= 20; n++) begin
      cycle(1'b1, 32'(n), 1'b1);
      chk($sformatf("stream_level[%0d]", n), 32'(level), 32'd1);
    end
    cycle(1'b0, 32'h0, 1'b1);
    chk("stream_drained", 32'(level), 32'd0);

    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h21 + 32'(i), 1'b0);
    chk("pre_reset_level", 32'(level), 32'd3);
    do_reset(1'b1, 1'b1);
    chk("midreset_level", 32'(level), 32'd0);
    chk("midreset_pull_rdy", 32'(pull_rdy), 32'd0);
    chk("midreset_push_rdy", 32'(push_rdy), 32'd1);
    chk_flags();
    cycle(1'b1, 32'hCC, 1'b0);
    chk("cc_pull_rdy", 32'(pull_rdy), 32'd1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("cc_only_level", 32'(level), 32'd0);
    chk("cc_only_pull_rdy", 32'(pull_rdy), 32'd0);

    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h70 + 32'(i), 1'b0);
    chk("err_full_level", 32'(level), 32'd4);
    cycle(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
    chk("err_drain_level", 32'(level), 32'd0);
    do_reset(1'b0, 1'b0);
    chk_flags();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
